picoblaze_port_sender: RTL and testbench

PICOBLAZE_PORT_SENDER -- requirements
Module: picoblaze_port_sender

---
 rtl/picoblaze_port_sender_pkg.sv | 33 +++
 rtl/port_sender_sel.sv | 24 ++
 rtl/picoblaze_port_sender.sv | 159 +++++++++++++++
 tb/tb_picoblaze_port_sender.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/picoblaze_port_sender_pkg.sv
// rtl/picoblaze_port_sender_pkg.sv - shared constants, FSM encoding and BCD helper for the port sender
package picoblaze_port_sender_pkg;

  localparam int IDX_W     = 4;
  localparam int N_ENTRIES = 10;

  localparam logic [7:0] PORT_BASE            = 8'h21;
  localparam logic [7:0] PORT_SEG_HORA        = 8'h21;
  localparam logic [7:0] PORT_MIN_HORA        = 8'h22;
  localparam logic [7:0] PORT_HORA_HORA       = 8'h23;
  localparam logic [7:0] PORT_DIA_FECHA       = 8'h24;
  localparam logic [7:0] PORT_MES_FECHA       = 8'h25;
  localparam logic [7:0] PORT_JAHR_FECHA      = 8'h26;
  localparam logic [7:0] PORT_SEG_TIMER       = 8'h27;
  localparam logic [7:0] PORT_MIN_TIMER       = 8'h28;
  localparam logic [7:0] PORT_HORA_TIMER      = 8'h29;
  localparam logic [7:0] PORT_BANDERAS_CONFIG = 8'h2A;

  // The flags entry is a raw bitfield, not a BCD value.
  localparam logic [IDX_W-1:0] FLAGS_IDX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  function automatic logic is_bcd(input logic [7:0] value);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/port_sender_sel.sv
// rtl/port_sender_sel.sv - priority encoder picking the lowest entry still pending in the mask
module port_sender_sel
  import picoblaze_port_sender_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [N-1:0]     mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Sent entries are cleared from the mask, so the lowest set bit is the next index above the current one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/picoblaze_port_sender.sv
// rtl/picoblaze_port_sender.sv - buffered PicoBlaze-style OUTPUT port sender
// Optional feature: define PORT_SENDER_BCD_CHECK_EN to skip non-BCD entries and flag bcd_err.
module picoblaze_port_sender
  import picoblaze_port_sender_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int N_REGS     = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              send,
  input  logic [N_REGS-1:0] send_mask,
  output logic [7:0]        port_id,
  output logic [7:0]        out_dato,
  output logic              write_strobe,
  output logic              k_write_strobe,
  output logic              busy,
  output logic              done,
  output logic              bcd_err
);

  localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t            state, state_n;
  logic [7:0]        regs [N_REGS];
  logic [7:0]        view [N_REGS];
  logic [N_REGS-1:0] remaining;
  logic [N_REGS-1:0] ok_mask;
  logic [N_REGS-1:0] mask_eff;
  logic [N_REGS-1:0] sel_in;
  logic [N_REGS-1:0] sel_bit;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [3:0]        gap_cnt;
  logic              wr_ok;
  logic              send_ok;
  logic              load;
  logic              fin;

  assign busy           = (state != IDLE);
  assign write_strobe   = (state == STROBE);
  assign k_write_strobe = 1'b0;
  assign wr_ok          = wr_en && !busy && (wr_addr < IDX_W'(N_REGS));
  assign send_ok        = send && !busy;

  // A write in the same cycle as send must be visible to that transfer.
  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      view[i] = (wr_ok && (wr_addr == IDX_W'(i))) ? wr_data : regs[i];
    end
  end

`ifdef PORT_SENDER_BCD_CHECK_EN
  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      ok_mask[i] = (IDX_W'(i) == FLAGS_IDX) || is_bcd(view[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_err <= 1'b0;
    end else if (send_ok && |(send_mask & ~ok_mask)) begin
      bcd_err <= 1'b1;
    end
  end
`else
  assign ok_mask = '1;
  assign bcd_err = 1'b0;
`endif

  assign mask_eff = send_mask & ok_mask;
  assign sel_in   = (state == IDLE) ? mask_eff : remaining;
  assign sel_bit  = N_REGS'(1) << sel_idx;

  port_sender_sel #(
    .N(N_REGS)
  ) u_sel (
    .mask (sel_in),
    .found(sel_found),
    .idx  (sel_idx)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (send_ok && sel_found) begin
          state_n = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: state_n = STROBE;
      STROBE: begin
        if (GAP_CYCLES > 0) begin
          state_n = GAP;
        end else if (sel_found) begin
          state_n = SETUP;
          load    = 1'b1;
        end else begin
          state_n = IDLE;
          fin     = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          if (sel_found) begin
            state_n = SETUP;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
            fin     = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      port_id   <= 8'h00;
      out_dato  <= 8'h00;
      remaining <= '0;
      gap_cnt   <= 4'd0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= fin || (send_ok && !sel_found);
      if (load) begin
        port_id   <= PORT_BASE + {4'b0000, sel_idx};
        out_dato  <= view[sel_idx];
        remaining <= sel_in & ~sel_bit;
      end
      if (state == STROBE) begin
        gap_cnt <= GAP_INIT;
      end else if (state == GAP && gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_picoblaze_port_sender.sv
// tb/tb_picoblaze_port_sender.sv - scoreboard bench for picoblaze_port_sender
module tb_picoblaze_port_sender;

  localparam int G = 2;

  typedef struct {
    int         cyc;
    logic [7:0] port;
    logic [7:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'h00;
  logic       send = 1'b0;
  logic [9:0] send_mask = 10'h000;
  logic [7:0] port_id;
  logic [7:0] out_dato;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       busy;
  logic       done;
  logic       bcd_err;

  int         cyc = 0;
  int         tests = 0;
  int         errs = 0;
  exp_t       exp_q[$];
  logic [7:0] mem [10];
  logic       exp_bcd = 1'b0;
  bit         active = 1'b0;
  int         t0 = 0;
  int         tdone = 0;

  picoblaze_port_sender #(
    .GAP_CYCLES(G),
    .N_REGS    (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .send          (send),
    .send_mask     (send_mask),
    .port_id       (port_id),
    .out_dato      (out_dato),
    .write_strobe  (write_strobe),
    .k_write_strobe(k_write_strobe),
    .busy          (busy),
    .done          (done),
    .bcd_err       (bcd_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (write_strobe) begin
        check("k_write_strobe", 32'(k_write_strobe), 32'd0);
        if (exp_q.size() == 0) begin
          check("extra_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_cycle", 32'(cyc), 32'(e.cyc));
          check("port_id", 32'(port_id), 32'(e.port));
          check("out_dato", 32'(out_dato), 32'(e.data));
        end
      end
      if (active) begin
        check("busy", 32'(busy), 32'(cyc > t0 && cyc < tdone));
        check("done", 32'(done), 32'(cyc == tdone));
        if (cyc >= tdone) active = 1'b0;
      end else if (done) begin
        check("spurious_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic write_entry(input logic [3:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    if (addr < 4'd10) mem[addr] = data;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // Expected strobes come from the model buffer at the moment send is driven.
  task automatic start_xfer(input logic [9:0] mask, input bit do_wr,
                            input logic [3:0] addr, input logic [7:0] data);
    int k;
    bit ok;
    exp_t e;
    if (do_wr) begin
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      if (addr < 4'd10) mem[addr] = data;
    end
    k = 0;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      if (mask[i]) begin
        ok = 1'b1;
`ifdef PORT_SENDER_BCD_CHECK_EN
        if (i != 9 && (mem[i][7:4] > 4'd9 || mem[i][3:0] > 4'd9)) begin
          ok = 1'b0;
          exp_bcd = 1'b1;
        end
`endif
        if (ok) begin
          e.cyc  = t0 + 2 + k * (2 + G);
          e.port = 8'h21 + 8'(i);
          e.data = mem[i];
          exp_q.push_back(e);
          k++;
        end
      end
    end
    tdone = (k == 0) ? t0 + 1 : t0 + 2 + (k - 1) * (2 + G) + 1 + G;
    active = 1'b1;
    send = 1'b1;
    send_mask = mask;
    @(negedge clock);
    send  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (active && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (active) begin
      check("timeout", 32'd0, 32'd1);
      active = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 10; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_port_id", 32'(port_id), 32'd0);
    check("rst_out_dato", 32'(out_dato), 32'd0);
    check("rst_write_strobe", 32'(write_strobe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd_err", 32'(bcd_err), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Full buffer, all entries selected; out-of-range addresses must not alias.
    for (int i = 0; i < 10; i++) write_entry(4'(i), 8'(i));
    write_entry(4'd10, 8'hEE);
    write_entry(4'd15, 8'hFF);
    start_xfer(10'h3FF, 1'b0, 4'd0, 8'h00);
    wait_done();

    start_xfer(10'b0000100100, 1'b0, 4'd0, 8'h00);
    wait_done();

    // Same-cycle write and send uses the new value.
    start_xfer(10'h010, 1'b1, 4'd4, 8'h44);
    wait_done();

    // Send, mask change and write while busy are all ignored.
    start_xfer(10'h3FF, 1'b0, 4'd0, 8'h00);
    repeat (3) @(negedge clock);
    send = 1'b1;
    send_mask = 10'h001;
    wr_en = 1'b1;
    wr_addr = 4'd0;
    wr_data = 8'h55;
    @(negedge clock);
    send = 1'b0;
    wr_en = 1'b0;
    wait_done();
    start_xfer(10'h001, 1'b0, 4'd0, 8'h00);
    wait_done();

    start_xfer(10'h000, 1'b0, 4'd0, 8'h00);
    wait_done();
    repeat (2) @(negedge clock);

    write_entry(4'd1, 8'h7A);
    start_xfer(10'h007, 1'b0, 4'd0, 8'h00);
    wait_done();
    check("bcd_err", 32'(bcd_err), 32'(exp_bcd));
    start_xfer(10'h001, 1'b0, 4'd0, 8'h00);
    wait_done();
    check("bcd_err_sticky", 32'(bcd_err), 32'(exp_bcd));

    // Reset during the third strobe of a full transfer.
    for (int i = 0; i < 10; i++) write_entry(4'(i), 8'h90 + 8'(i));
    start_xfer(10'h3FF, 1'b0, 4'd0, 8'h00);
    while (cyc < t0 + 2 + 2 * (2 + G)) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_port_id", 32'(port_id), 32'd0);
    check("mid_rst_out_dato", 32'(out_dato), 32'd0);
    check("mid_rst_write_strobe", 32'(write_strobe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd_err", 32'(bcd_err), 32'd0);
    exp_q.delete();
    active = 1'b0;
    exp_bcd = 1'b0;
    for (int i = 0; i < 10; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    start_xfer(10'h3FF, 1'b0, 4'd0, 8'h00);
    wait_done();

    repeat (3) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
